// File: rtl/systolic_iact_feeder.sv
// rtl/systolic_iact_feeder.sv - skewed input-activation feeder for the left edge of the PE array
module systolic_iact_feeder #(
    parameter int N      = 4,   // array rows / lanes
    parameter int DATA_W = 16,  // activation width
    parameter int SKEW   = 1    // per-lane delay step in cycles
) (
    input  logic                clk,         // rising-edge clock
    input  logic                rst_n,       // synchronous active-low reset
    input  logic                in_valid,    // upstream vector valid
    output logic                in_ready,    // feeder can accept a vector
    input  logic [N*DATA_W-1:0] in_vec,      // lane i = [i*DATA_W +: DATA_W]
    input  logic                in_last,     // final vector of the tile
    output logic [N*DATA_W-1:0] iact_out,    // lane i feeds row i, column 0
    output logic [N-1:0]        iact_valid,  // per-lane valid
    output logic                busy,        // not idle
    output logic                done         // tile fully presented
);

    localparam int DRAIN_CYC = (N - 1) * SKEW;
    localparam int CNT_W     = (DRAIN_CYC == 0) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  drain_cnt;
    logic              accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : STREAM;
            STREAM:  if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            STREAM:  begin in_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: in_ready = 1'b0;
        endcase
    end

    // Counter covers the extra cycles the deepest lane needs after the
    // final accept; it is loaded on the transition into DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state != DRAIN && state_nxt == DRAIN) begin
            drain_cnt <= CNT_W'(DRAIN_CYC);
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int DEPTH = 1 + i * SKEW;

        logic [DATA_W-1:0] sh_data [DEPTH];
        logic              sh_vld  [DEPTH];

        // Stage 0 loads zero on non-accept cycles so bubbles carry no stale data.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    sh_data[k] <= '0;
                    sh_vld[k]  <= 1'b0;
                end
            end else begin
                sh_data[0] <= accept ? in_vec[i*DATA_W +: DATA_W] : '0;
                sh_vld[0]  <= accept;
                for (int k = 1; k < DEPTH; k++) begin
                    sh_data[k] <= sh_data[k-1];
                    sh_vld[k]  <= sh_vld[k-1];
                end
            end
        end

        assign iact_out[i*DATA_W +: DATA_W] = sh_vld[DEPTH-1] ? sh_data[DEPTH-1] : '0;
        assign iact_valid[i]                = sh_vld[DEPTH-1];
    end

endmodule

// File: tb/tb_systolic_iact_feeder.sv
// tb/tb_systolic_iact_feeder.sv - directed self-checking bench for systolic_iact_feeder
module tb_systolic_iact_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic [63:0] in_vec;

    logic        in_ready, busy, done;
    logic [63:0] iact_out;
    logic [3:0]  iact_valid;

    logic        s_ready, s_busy, s_done;
    logic [63:0] s_out;
    logic [3:0]  s_valid;

    logic        n_ready, n_busy, n_done;
    logic [15:0] n_out;
    logic [0:0]  n_valid;

    int checks = 0;
    int errors = 0;

    logic [63:0] stim_vec  [16];
    logic        stim_val  [16];
    logic        stim_last [16];
    logic        exp_acc   [16];
    logic        exp_done  [16];
    logic        exp_rdy   [16];
    logic        exp_busy  [16];

    always #5 clk = ~clk;

    systolic_iact_feeder #(.N(4), .DATA_W(16), .SKEW(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_last(in_last), .iact_out(iact_out),
        .iact_valid(iact_valid), .busy(busy), .done(done)
    );

    systolic_iact_feeder #(.N(4), .DATA_W(16), .SKEW(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready),
        .in_vec(in_vec), .in_last(in_last), .iact_out(s_out),
        .iact_valid(s_valid), .busy(s_busy), .done(s_done)
    );

    systolic_iact_feeder #(.N(1), .DATA_W(16), .SKEW(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_ready),
        .in_vec(in_vec[15:0]), .in_last(in_last), .iact_out(n_out),
        .iact_valid(n_valid), .busy(n_busy), .done(n_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int k = 0; k < 16; k++) begin
            stim_vec[k] = '0; stim_val[k] = 1'b0; stim_last[k] = 1'b0;
            exp_acc[k] = 1'b0; exp_done[k] = 1'b0; exp_rdy[k] = 1'b0; exp_busy[k] = 1'b0;
        end
    endtask

    // Cycle c is the cycle after edge c-1; lane i shows what was accepted at edge c-1-i.
    task automatic run(input string name, input int ncyc);
        logic [63:0] eo;
        logic [3:0]  ev;
        for (int c = 1; c <= ncyc; c++) begin
            in_valid = stim_val[c-1];
            in_vec   = stim_vec[c-1];
            in_last  = stim_last[c-1];
            tick();
            eo = '0;
            ev = '0;
            for (int i = 0; i < 4; i++) begin
                if (c - 1 - i >= 0 && exp_acc[c-1-i]) begin
                    eo[i*16 +: 16] = stim_vec[c-1-i][i*16 +: 16];
                    ev[i] = 1'b1;
                end
            end
            chk($sformatf("%s_data_c%0d", name, c), iact_out, eo);
            chk($sformatf("%s_valid_c%0d", name, c), 64'(iact_valid), 64'(ev));
            chk($sformatf("%s_done_c%0d", name, c), 64'(done), 64'(exp_done[c]));
            chk($sformatf("%s_ready_c%0d", name, c), 64'(in_ready), 64'(exp_rdy[c]));
            chk($sformatf("%s_busy_c%0d", name, c), 64'(busy), 64'(exp_busy[c]));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_vec   = '0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
        clear();

        // reset values
        tick(); tick(); tick();
        chk("rst_out", iact_out, 64'h0);
        chk("rst_valid", 64'(iact_valid), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1;

        // skew: three vectors, last at edge 2; done in cycle 7 only
        clear();
        stim_vec[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        stim_vec[1] = {16'd8, 16'd7, 16'd6, 16'd5};
        stim_vec[2] = {16'd12, 16'd11, 16'd10, 16'd9};
        for (int k = 0; k < 3; k++) begin stim_val[k] = 1'b1; exp_acc[k] = 1'b1; end
        stim_last[2] = 1'b1;
        exp_done[7] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            exp_rdy[c]  = (c <= 2) || (c >= 8);
            exp_busy[c] = (c <= 7);
        end
        run("skew", 8);

        // bubble between two vectors; negative data passes unchanged
        clear();
        stim_vec[0] = {4{16'h0001}};
        stim_vec[2] = {4{16'hFFFE}};
        stim_val[0] = 1'b1; stim_val[2] = 1'b1; stim_last[2] = 1'b1;
        exp_acc[0] = 1'b1; exp_acc[2] = 1'b1;
        exp_done[7] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            exp_rdy[c]  = (c <= 2) || (c >= 8);
            exp_busy[c] = (c <= 7);
        end
        run("bubble", 8);

        // single-vector tile from IDLE
        clear();
        stim_vec[0] = {16'hFFFF, 16'h0000, 16'h0000, 16'h0007};
        stim_val[0] = 1'b1; stim_last[0] = 1'b1; exp_acc[0] = 1'b1;
        exp_done[5] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            exp_rdy[c]  = (c == 6);
            exp_busy[c] = (c <= 5);
        end
        run("single", 6);

        // backpressure: next vector held valid through DRAIN/DONE, accepted after done
        clear();
        stim_vec[0] = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        stim_val[0] = 1'b1; stim_last[0] = 1'b1; exp_acc[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            stim_vec[k]  = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
            stim_val[k]  = 1'b1;
            stim_last[k] = 1'b1;
        end
        exp_acc[6] = 1'b1;
        exp_done[5] = 1'b1; exp_done[11] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            exp_rdy[c]  = (c == 6) || (c == 12);
            exp_busy[c] = (c != 6) && (c != 12);
        end
        run("bp", 12);

        // reset mid-STREAM: outputs cleared next cycle, no done afterwards
        in_valid = 1'b1; in_last = 1'b0; in_vec = {16'd4, 16'd3, 16'd2, 16'd1};
        tick(); tick();
        chk("mid_busy_before", 64'(busy), 64'h1);
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_out", iact_out, 64'h0);
        chk("mid_rst_valid", 64'(iact_valid), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("mid_nodone_%0d", c), 64'(done), 64'h0);
            chk($sformatf("mid_noout_%0d", c), 64'(iact_valid), 64'h0);
            tick();
        end

        // parameter corners: SKEW=0 and N=1 present at t+1, done at t+2
        in_valid = 1'b1; in_last = 1'b1;
        in_vec = {16'h8001, 16'h7FFF, 16'h0100, 16'hFFFF};
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
        chk("s0_out_c1", s_out, {16'h8001, 16'h7FFF, 16'h0100, 16'hFFFF});
        chk("s0_valid_c1", 64'(s_valid), 64'hF);
        chk("s0_done_c1", 64'(s_done), 64'h0);
        chk("s0_ready_c1", 64'(s_ready), 64'h0);
        chk("n1_out_c1", 64'(n_out), 64'hFFFF);
        chk("n1_valid_c1", 64'(n_valid), 64'h1);
        chk("n1_done_c1", 64'(n_done), 64'h0);
        tick();
        chk("s0_out_c2", s_out, 64'h0);
        chk("s0_done_c2", 64'(s_done), 64'h1);
        chk("s0_busy_c2", 64'(s_busy), 64'h1);
        chk("n1_valid_c2", 64'(n_valid), 64'h0);
        chk("n1_done_c2", 64'(n_done), 64'h1);
        chk("n1_busy_c2", 64'(n_busy), 64'h1);
        tick();
        chk("s0_done_c3", 64'(s_done), 64'h0);
        chk("s0_ready_c3", 64'(s_ready), 64'h1);
        chk("n1_done_c3", 64'(n_done), 64'h0);
        chk("n1_ready_c3", 64'(n_ready), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
